// File: rtl/gbe_udp_rx_frame_gen.sv
// Ethernet/IPv4/UDP frame source for the MAC receive side: one byte per cycle,
// no preamble/FCS, followed by a single good/bad status pulse and an idle gap.
//
// state   | meaning
// IDLE    | waiting for a start request with a legal payload length
// CALC    | IPv4 header checksum computed from the latched length
// HDR     | bytes 0-41: Ethernet, IPv4 and UDP headers
// PAYLOAD | incrementing payload bytes starting at the latched seed
// PAD     | zero bytes up to the 60-byte minimum frame
// STATUS  | good/bad frame pulse, frame counter bump
// GAP     | IFG quiet cycles before returning to IDLE
module gbe_udp_rx_frame_gen #(
    parameter logic [47:0] DST_MAC  = 48'h123456789abc,
    parameter logic [47:0] SRC_MAC  = 48'h020000000001,
    parameter logic [31:0] SRC_IP   = {8'd192, 8'd168, 8'd64, 8'd1},
    parameter logic [31:0] DST_IP   = {8'd100, 8'd101, 8'd102, 8'd103},
    parameter logic [15:0] SRC_PORT = 16'hbeef,
    parameter logic [15:0] DST_PORT = 16'hdead,
    parameter int unsigned IFG      = 12
) (
    input  logic        mac_clk,
    input  logic        mac_rst,
    input  logic        start,
    input  logic [10:0] payload_len,
    input  logic [7:0]  payload_seed,
    input  logic        corrupt,
    output logic [7:0]  mac_rx_data,
    output logic        mac_rx_dvld,
    output logic        mac_rx_goodframe,
    output logic        mac_rx_badframe,
    output logic        busy,
    output logic [15:0] frame_count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CALC    = 3'd1;
    localparam logic [2:0] S_HDR     = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_PAD     = 3'd4;
    localparam logic [2:0] S_STATUS  = 3'd5;
    localparam logic [2:0] S_GAP     = 3'd6;

    localparam logic [7:0] IFG_M1 = 8'(IFG - 1);

    logic [2:0]  r_state;
    logic [10:0] r_len;
    logic [7:0]  r_seed;
    logic        r_corrupt;
    logic [15:0] r_csum;
    logic [10:0] r_pos;
    logic [7:0]  r_gap_cnt;
    logic [7:0]  r_data;
    logic        r_dvld;
    logic        r_good;
    logic        r_bad;
    logic        r_busy;
    logic [15:0] r_frame_count;

    logic          w_len_ok;
    logic [15:0]   w_total_len;
    logic [15:0]   w_udp_len;
    logic [19:0]   w_sum_raw;
    logic [16:0]   w_sum_f1;
    logic [15:0]   w_sum_f2;
    logic [15:0]   w_csum;
    logic [10:0]   w_last_pos;
    logic          w_is_last;
    logic [10:0]   w_next_pos;
    logic [10:0]   w_pay_end;
    logic [335:0]  w_hdr;
    logic [8:0]    w_hdr_idx;
    logic [7:0]    w_byte;
    logic [2:0]    w_region;

    assign w_len_ok    = (payload_len != 11'd0) && (payload_len <= 11'd1472);
    assign w_total_len = 16'd28 + {5'd0, r_len};
    assign w_udp_len   = 16'd8 + {5'd0, r_len};

    // Two folds suffice: after the first the carry out is at most one.
    assign w_sum_raw = 20'h04500 + {4'd0, w_total_len} + 20'h04000 + 20'h04011
                     + {4'd0, SRC_IP[31:16]} + {4'd0, SRC_IP[15:0]}
                     + {4'd0, DST_IP[31:16]} + {4'd0, DST_IP[15:0]};
    assign w_sum_f1  = {1'b0, w_sum_raw[15:0]} + {13'd0, w_sum_raw[19:16]};
    assign w_sum_f2  = w_sum_f1[15:0] + {15'd0, w_sum_f1[16]};
    assign w_csum    = ~w_sum_f2;

    // Short payloads (42+len < 60) are padded out to a 60-byte frame.
    assign w_last_pos = (r_len < 11'd18) ? 11'd59 : (r_len + 11'd41);
    assign w_is_last  = (r_pos == w_last_pos);
    assign w_next_pos = (r_state == S_CALC) ? 11'd0 : (r_pos + 11'd1);
    assign w_pay_end  = r_len + 11'd42;

    assign w_hdr = {DST_MAC, SRC_MAC, 16'h0800,
                    16'h4500, w_total_len, 16'h0000, 16'h4000, 16'h4011, r_csum,
                    SRC_IP, DST_IP,
                    SRC_PORT, DST_PORT, w_udp_len, 16'h0000};
    assign w_hdr_idx = 9'd335 - {w_next_pos[5:0], 3'b000};

    always_comb begin
        w_byte   = 8'h00;
        w_region = S_PAD;
        if (w_next_pos < 11'd42) begin
            w_byte   = w_hdr[w_hdr_idx -: 8];
            w_region = S_HDR;
        end else if (w_next_pos < w_pay_end) begin
            w_byte   = r_seed + w_next_pos[7:0] - 8'd42;
            w_region = S_PAYLOAD;
        end
    end

    always_ff @(posedge mac_clk or posedge mac_rst) begin
        if (mac_rst) begin
            r_state       <= S_IDLE;
            r_len         <= 11'd0;
            r_seed        <= 8'd0;
            r_corrupt     <= 1'b0;
            r_csum        <= 16'd0;
            r_pos         <= 11'd0;
            r_gap_cnt     <= 8'd0;
            r_data        <= 8'd0;
            r_dvld        <= 1'b0;
            r_good        <= 1'b0;
            r_bad         <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_count <= 16'd0;
        end else begin
            r_good <= 1'b0;
            r_bad  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && w_len_ok) begin
                        r_len     <= payload_len;
                        r_seed    <= payload_seed;
                        r_corrupt <= corrupt;
                        r_busy    <= 1'b1;
                        r_state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_csum  <= w_csum;
                    r_pos   <= w_next_pos;
                    r_data  <= w_byte;
                    r_dvld  <= 1'b1;
                    r_state <= w_region;
                end
                S_HDR, S_PAYLOAD, S_PAD: begin
                    if (w_is_last) begin
                        r_data        <= 8'd0;
                        r_dvld        <= 1'b0;
                        r_good        <= ~r_corrupt;
                        r_bad         <= r_corrupt;
                        r_frame_count <= r_frame_count + 16'd1;
                        r_state       <= S_STATUS;
                    end else begin
                        r_pos   <= w_next_pos;
                        r_data  <= w_byte;
                        r_state <= w_region;
                    end
                end
                S_STATUS: begin
                    r_gap_cnt <= IFG_M1;
                    r_state   <= S_GAP;
                end
                S_GAP: begin
                    if (r_gap_cnt == 8'd0) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mac_rx_data      = r_data;
    assign mac_rx_dvld      = r_dvld;
    assign mac_rx_goodframe = r_good;
    assign mac_rx_badframe  = r_bad;
    assign busy             = r_busy;
    assign frame_count      = r_frame_count;

endmodule
